counter_cmd_arbiter: RTL and testbench

Command sequencer and arbiter in front of the shared up/down/load counter (ld, updn, data, and a count enable).
Two requesters each submit one command over valid/ready. Commands are: count up, count down, load-then-up, load-then-down, each with a repeat count.
The block grants one requester at a time (round-robin), drives the counter's control pins for the exact number of cycles, then reports the final counter value with a one-cycle done pulse.

---
 rtl/counter_cmd_arbiter.sv | 141 ++++++++++++++
 tb/tb_counter_cmd_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_cmd_arbiter.sv
// Round-robin arbiter and command sequencer for a shared up/down/load counter.
// Each granted command drives ld/en/updn for an exact number of cycles, then reports the result.
module counter_cmd_arbiter #(
  parameter int WIDTH = 4,
  parameter int RPT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_mode,
  input  logic [RPT_W-1:0] req0_rpt,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_mode,
  input  logic [RPT_W-1:0] req1_rpt,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [WIDTH-1:0] cnt_q,
  output logic             ld,
  output logic             updn,
  output logic             en,
  output logic [WIDTH-1:0] data,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             id_q, id_d;
  logic [1:0]       mode_q, mode_d;
  logic [RPT_W-1:0] remain_q, remain_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic             grant;
  logic             xfer;
  logic [1:0]       sel_mode;
  logic [RPT_W-1:0] sel_rpt;
  logic [WIDTH-1:0] sel_data;

  // A lone requester always wins; on contention the one not served last time wins.
  always_comb begin
    grant = req1_valid;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end
    req0_ready = (state_q == IDLE) && req0_valid && !grant;
    req1_ready = (state_q == IDLE) && req1_valid && grant;
    xfer       = req0_ready || req1_ready;
    sel_mode   = grant ? req1_mode : req0_mode;
    sel_rpt    = grant ? req1_rpt  : req0_rpt;
    sel_data   = grant ? req1_data : req0_data;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    mode_d       = mode_q;
    remain_d     = remain_q;
    data_d       = data_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          id_d         = grant;
          last_grant_d = grant;
          mode_d       = sel_mode;
          remain_d     = sel_rpt;
          data_d       = sel_data;
          if (sel_mode[1]) begin
            state_d = LOAD;
          end else if (sel_rpt != '0) begin
            state_d = RUN;
          end else begin
            state_d = DONE;
          end
        end
      end
      LOAD: state_d = (remain_q != '0) ? RUN : DONE;
      RUN: begin
        remain_d = remain_q - 1'b1;
        if (remain_q == RPT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      mode_q       <= '0;
      remain_q     <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      mode_q       <= mode_d;
      remain_q     <= remain_d;
      data_q       <= data_d;
    end
  end

  // Counter pins are zero outside the state that owns them.
  always_comb begin
    ld      = 1'b0;
    updn    = 1'b0;
    en      = 1'b0;
    data    = '0;
    done    = 1'b0;
    done_id = 1'b0;
    result  = '0;
    busy    = (state_q != IDLE);
    case (state_q)
      LOAD: begin
        ld   = 1'b1;
        data = data_q;
      end
      RUN: begin
        en   = 1'b1;
        updn = ~mode_q[0];
      end
      DONE: begin
        done    = 1'b1;
        done_id = id_q;
        result  = cnt_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_counter_cmd_arbiter.sv
// Bench for counter_cmd_arbiter: directed cases plus randomized two-requester traffic,
// checked against a command-level model of grant order, latency and final counter value.
module tb_counter_cmd_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [1:0] req0_mode = '0, req1_mode = '0;
  logic [7:0] req0_rpt = '0, req1_rpt = '0;
  logic [3:0] req0_data = '0, req1_data = '0;
  logic [3:0] cnt = 4'h0;
  logic       ld, updn, en, busy, done, done_id;
  logic [3:0] data, result;

  int errs = 0;
  int checks = 0;
  int cyc = 0;

  counter_cmd_arbiter #(.WIDTH(4), .RPT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode(req0_mode),
    .req0_rpt(req0_rpt), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode(req1_mode),
    .req1_rpt(req1_rpt), .req1_data(req1_data),
    .cnt_q(cnt), .ld(ld), .updn(updn), .en(en), .data(data),
    .busy(busy), .done(done), .done_id(done_id), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // The shared counter the arbiter controls.
  always @(posedge clk) begin
    if (ld) cnt <= data;
    else if (en) cnt <= updn ? cnt + 4'd1 : cnt - 4'd1;
  end

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Command-level reference model and scoreboard.
  bit   pend = 0;
  bit   mlast = 1;
  int   e_id, e_rpt, e_res, e_lat, acc_cyc, n_ld, n_en, n_bad;
  logic [1:0] e_mode;
  logic [3:0] e_data, ld_seen;
  int   v_both = 0, v_busy_ready = 0, v_nogrant = 0, v_spur = 0, v_stray = 0;
  int   last_res = -1, last_id = -1;
  int   glog[$];

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        pend  = 0;
        mlast = 1;
      end else begin
        bit pend0;
        pend0 = pend;
        if (req0_ready && req1_ready) v_both++;
        if (pend0 && (req0_ready || req1_ready)) v_busy_ready++;
        if (pend0) begin
          if (ld) begin n_ld++; ld_seen = data; end
          if (en) begin
            n_en++;
            if (updn !== ~e_mode[0]) n_bad++;
          end
        end else if (ld || en || done) begin
          v_stray++;
        end
        if (done && pend0) begin
          check_val("done_id", done_id, e_id);
          check_val("result", result, e_res);
          check_val("latency", cyc - acc_cyc, e_lat);
          check_val("ld_cycles", n_ld, e_mode[1]);
          check_val("en_cycles", n_en, e_rpt);
          check_val("updn_bad", n_bad, 0);
          if (e_mode[1]) check_val("ld_data", ld_seen, e_data);
          last_res = result;
          last_id  = done_id;
          pend     = 0;
        end
        if (!pend0 && (req0_valid || req1_valid)) begin
          bit exp_g, got_g;
          int start;
          exp_g = (req0_valid && req1_valid) ? ~mlast : req1_valid;
          if (!(req0_ready || req1_ready)) begin
            v_nogrant++;
          end else begin
            got_g = req1_ready;
            check_val("grant", got_g, exp_g);
            mlast   = got_g;
            e_id    = got_g;
            e_mode  = got_g ? req1_mode : req0_mode;
            e_rpt   = got_g ? req1_rpt  : req0_rpt;
            e_data  = got_g ? req1_data : req0_data;
            start   = e_mode[1] ? int'(e_data) : int'(cnt);
            e_res   = e_mode[0] ? ((start - e_rpt) & 15) : ((start + e_rpt) & 15);
            e_lat   = e_rpt + 1 + e_mode[1];
            acc_cyc = cyc;
            n_ld = 0; n_en = 0; n_bad = 0;
            pend = 1;
            glog.push_back(got_g);
          end
        end
      end
    end
  end

  task automatic send0(input logic [1:0] m, input logic [7:0] r, input logic [3:0] d);
    bit ok = 0;
    req0_mode = m; req0_rpt = r; req0_data = d; req0_valid = 1'b1;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (req0_ready) ok = 1;
    end
    if (!ok) check_val("req0_timeout", 0, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
  endtask

  task automatic send1(input logic [1:0] m, input logic [7:0] r, input logic [3:0] d);
    bit ok = 0;
    req1_mode = m; req1_rpt = r; req1_data = d; req1_valid = 1'b1;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (req1_ready) ok = 1;
    end
    if (!ok) check_val("req1_timeout", 0, 1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (!pend && !busy && !req0_valid && !req1_valid) ok = 1;
    end
    if (!ok) check_val("idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  function automatic logic [7:0] rand_rpt();
    return ($urandom_range(0, 7) == 0) ? 8'($urandom_range(200, 255)) : 8'($urandom_range(0, 12));
  endfunction

  initial begin
    #2;
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_en", en, 0);
    check_val("rst_ld", ld, 0);
    #21 rst = 1'b1;
    @(posedge clk); #1;

    send0(2'd2, 8'd3, 4'd4); wait_idle();
    check_val("tp_load_up_res", last_res, 7);
    check_val("tp_load_up_id", last_id, 0);
    $display("txn load+up  id=%0d result=%0d", last_id, last_res);

    send1(2'd3, 8'd6, 4'd4); wait_idle();
    check_val("tp_load_dn_res", last_res, 14);
    check_val("tp_load_dn_id", last_id, 1);
    $display("txn load+dn  id=%0d result=%0d", last_id, last_res);

    send0(2'd2, 8'd0, 4'hF); wait_idle();
    check_val("tp_load_rpt0", last_res, 15);
    $display("txn load rpt0 id=%0d result=%0d", last_id, last_res);

    send0(2'd0, 8'd1, 4'd0); wait_idle();
    check_val("tp_up_wrap", last_res, 0);
    $display("txn up wrap  id=%0d result=%0d", last_id, last_res);

    send0(2'd1, 8'd0, 4'd0); wait_idle();
    check_val("tp_dn_rpt0", last_res, 0);
    $display("txn dn rpt0  id=%0d result=%0d", last_id, last_res);

    fork
      send0(2'd0, 8'd10, 4'd0);
      begin repeat (3) @(posedge clk); #1; send1(2'd1, 8'd2, 4'd0); end
    join
    wait_idle();
    check_val("busy_req_res", last_res, 8);
    check_val("busy_req_id", last_id, 1);
    $display("txn held while busy id=%0d result=%0d", last_id, last_res);

    send0(2'd0, 8'd20, 4'd0);
    repeat (5) @(posedge clk);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    check_val("arst_en", en, 0);
    check_val("arst_ld", ld, 0);
    check_val("arst_busy", busy, 0);
    check_val("arst_done", done, 0);
    $display("txn async reset mid-run busy=%0d en=%0d", busy, en);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #1;

    glog.delete();
    fork
      for (int i = 0; i < 3; i++) send0(2'd0, 8'd2, 4'd0);
      for (int i = 0; i < 3; i++) send1(2'd0, 8'd2, 4'd0);
    join
    wait_idle();
    check_val("rr_count", glog.size(), 6);
    for (int i = 0; i < glog.size(); i++) begin
      check_val("rr_order", glog[i], i % 2);
      $display("txn contention grant[%0d]=%0d", i, glog[i]);
    end

    fork
      for (int i = 0; i < 15; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        send0(2'($urandom_range(0, 3)), rand_rpt(), 4'($urandom_range(0, 15)));
        $display("txn rand req0 #%0d last_id=%0d result=%0d", i, last_id, last_res);
      end
      for (int i = 0; i < 15; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        send1(2'($urandom_range(0, 3)), rand_rpt(), 4'($urandom_range(0, 15)));
        $display("txn rand req1 #%0d last_id=%0d result=%0d", i, last_id, last_res);
      end
    join
    wait_idle();

    check_val("both_ready", v_both, 0);
    check_val("ready_while_busy", v_busy_ready, 0);
    check_val("idle_no_grant", v_nogrant, 0);
    check_val("spurious_done", v_spur, 0);
    check_val("stray_pins", v_stray, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
